// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the pipelined control unit.
//   - Opcode constants for the supported RV32I subset (lw, sw, R, I-ALU, branch, jal)
//   - ALUControl encodings (4-bit superset; narrow builds use the low 3 bits)
//   - ResultSrc encodings
//   - ALUOp enum used between the main decoder and the ALU decoder
//   - ctrl_bundle_t, the control bundle carried down the pipeline, and BUBBLE
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       aluSrc;
    logic       jump;
    logic       branch;
    logic [3:0] aluControl;
    logic [1:0] resultSrc;
  } ctrl_bundle_t;

  // An all-zero bundle performs no architectural side effect.
  localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: purely combinational Decode-stage control decode.
//   Main decode maps the opcode to the control bundle and ALUOp; the ALU
//   decode turns ALUOp/funct3/funct7 into ALUControl. Unknown opcodes, ALU
//   ops the configured ALU width cannot express and (with BRANCH_COND_EN)
//   branch funct3 010/011 raise illegal_o and yield a bubble.
// Parameters: ALUCTRL_W (3 = add/sub/and/or/slt, 4 = adds xor/sll/srl/sra)
// Macro:      BRANCH_COND_EN
// Ports:
//   op_i, funct3_i, funct7_i  instruction fields in Decode
//   immSrc_o                  immediate select (0 when illegal)
//   illegal_o                 instruction not supported by this build
//   ctrl_o                    control bundle (BUBBLE when illegal)
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic [6:0]   op_i,
  input  logic [2:0]   funct3_i,
  input  logic [6:0]   funct7_i,
  output logic [1:0]   immSrc_o,
  output logic         illegal_o,
  output ctrl_bundle_t ctrl_o
);

  ctrl_bundle_t mainCtrl;
  logic [1:0]   immSrc;
  alu_op_e      aluOp;
  logic         opKnown;
  logic [3:0]   aluCode;
  logic         aluExt;
  logic         aluExtIllegal;
  logic         branchFunctBad;
  logic         unusedFunct7;

  // Only funct7[5] distinguishes sub/sra; the other bits are ignored.
  assign unusedFunct7 = ^{funct7_i[6], funct7_i[4:0]};

  // Main decode: opcode to enables, immediate type and ALUOp class.
  always_comb begin
    mainCtrl = BUBBLE;
    immSrc   = 2'b00;
    aluOp    = ALUOP_ADD;
    opKnown  = 1'b1;
    case (op_i)
      OP_LOAD: begin
        mainCtrl.regWrite  = 1'b1;
        mainCtrl.aluSrc    = 1'b1;
        mainCtrl.resultSrc = RES_MEM;
      end
      OP_STORE: begin
        immSrc            = 2'b01;
        mainCtrl.aluSrc   = 1'b1;
        mainCtrl.memWrite = 1'b1;
      end
      OP_RTYPE: begin
        mainCtrl.regWrite = 1'b1;
        aluOp             = ALUOP_FUNCT;
      end
      OP_ITYPE: begin
        mainCtrl.regWrite = 1'b1;
        mainCtrl.aluSrc   = 1'b1;
        aluOp             = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        immSrc          = 2'b10;
        mainCtrl.branch = 1'b1;
        aluOp           = ALUOP_SUB;
      end
      OP_JAL: begin
        immSrc             = 2'b11;
        mainCtrl.regWrite  = 1'b1;
        mainCtrl.resultSrc = RES_PC4;
        mainCtrl.jump      = 1'b1;
      end
      default: opKnown = 1'b0;
    endcase
  end

  // ALU decode. aluExt marks the ops that need the 4-bit ALU.
  // Sub is only for R-type (op[5]=1); I-type with funct7[5] set is still addi.
  always_comb begin
    aluCode = ALU_ADD;
    aluExt  = 1'b0;
    case (aluOp)
      ALUOP_SUB: aluCode = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000: aluCode = (op_i[5] && funct7_i[5]) ? ALU_SUB : ALU_ADD;
          3'b111: aluCode = ALU_AND;
          3'b110: aluCode = ALU_OR;
          3'b010: aluCode = ALU_SLT;
          3'b100: begin
            aluCode = ALU_XOR;
            aluExt  = 1'b1;
          end
          3'b001: begin
            aluCode = ALU_SLL;
            aluExt  = 1'b1;
          end
          3'b101: begin
            aluCode = funct7_i[5] ? ALU_SRA : ALU_SRL;
            aluExt  = 1'b1;
          end
          default: aluCode = ALU_ADD;
        endcase
      end
      default: aluCode = ALU_ADD;
    endcase
  end

  assign aluExtIllegal = (ALUCTRL_W < 4) && aluExt;

`ifdef BRANCH_COND_EN
  // funct3 010/011 are not branch conditions.
  assign branchFunctBad = (op_i == OP_BRANCH) && (funct3_i[2:1] == 2'b01);
`else
  assign branchFunctBad = 1'b0;
`endif

  assign illegal_o = !opKnown || aluExtIllegal || branchFunctBad;

  // Anything illegal leaves Decode as a bubble.
  always_comb begin
    ctrl_o   = BUBBLE;
    immSrc_o = 2'b00;
    if (!illegal_o) begin
      ctrl_o            = mainCtrl;
      ctrl_o.aluControl = aluCode;
      immSrc_o          = immSrc;
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: control path of the 5-stage RISC-V core.
//   Decodes in D (ctrl_decoder), carries the control bundle through the E,
//   M and W pipeline registers and resolves PCSrcE in Execute.
//   E register priority: reset, FlushE (bubble), StallE (hold), load D.
//   M and W always advance. Reset is synchronous, active-low (rst).
// Parameters: ALUCTRL_W (3 or 4), RESULTSRC_W (ResultSrc width)
// Macro:      BRANCH_COND_EN - full beq/bne/blt/bge/bltu/bgeu conditions;
//             undefined, every branch resolves as beq on ZeroE.
// Ports:
//   clk, rst                          clock, sync active-low reset
//   OpD, funct3D, funct7D             Decode instruction fields
//   StallE, FlushE                    E register hold / bubble
//   ZeroE, LtE, LtuE                  ALU flags in Execute
//   ImmSrcD, IllegalD                 combinational Decode outputs
//   *E, *M, *W                        registered stage controls
//   PCSrcE                            taken branch/jump (combinational)
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int ALUCTRL_W   = 3,
  parameter int RESULTSRC_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [6:0]             OpD,
  input  logic [2:0]             funct3D,
  input  logic [6:0]             funct7D,
  input  logic                   StallE,
  input  logic                   FlushE,
  input  logic                   ZeroE,
  input  logic                   LtE,
  input  logic                   LtuE,
  output logic [1:0]             ImmSrcD,
  output logic                   IllegalD,
  output logic                   RegWriteE,
  output logic                   MemWriteE,
  output logic                   ALUSrcE,
  output logic                   JumpE,
  output logic                   BranchE,
  output logic [ALUCTRL_W-1:0]   ALUControlE,
  output logic [RESULTSRC_W-1:0] ResultSrcE,
  output logic                   PCSrcE,
  output logic                   RegWriteM,
  output logic                   MemWriteM,
  output logic [RESULTSRC_W-1:0] ResultSrcM,
  output logic                   RegWriteW,
  output logic [RESULTSRC_W-1:0] ResultSrcW
);

  ctrl_bundle_t ctrlD;
  ctrl_bundle_t ctrlE_d;
  ctrl_bundle_t ctrlE_q;
  logic         regWriteM_q;
  logic         memWriteM_q;
  logic [1:0]   resultSrcM_q;
  logic         regWriteW_q;
  logic [1:0]   resultSrcW_q;
  logic         branchCond;

  ctrl_decoder #(
    .ALUCTRL_W(ALUCTRL_W)
  ) u_decoder (
    .op_i      (OpD),
    .funct3_i  (funct3D),
    .funct7_i  (funct7D),
    .immSrc_o  (ImmSrcD),
    .illegal_o (IllegalD),
    .ctrl_o    (ctrlD)
  );

  // Flush wins over stall so a flushed-and-stalled slot becomes a bubble.
  always_comb begin
    ctrlE_d = ctrlD;
    if (FlushE) begin
      ctrlE_d = BUBBLE;
    end else if (StallE) begin
      ctrlE_d = ctrlE_q;
    end
  end

  // Execute pipeline register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrlE_q <= BUBBLE;
    end else begin
      ctrlE_q <= ctrlE_d;
    end
  end

  // Memory and Writeback registers keep only what those stages consume.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regWriteM_q  <= 1'b0;
      memWriteM_q  <= 1'b0;
      resultSrcM_q <= RES_ALU;
      regWriteW_q  <= 1'b0;
      resultSrcW_q <= RES_ALU;
    end else begin
      regWriteM_q  <= ctrlE_q.regWrite;
      memWriteM_q  <= ctrlE_q.memWrite;
      resultSrcM_q <= ctrlE_q.resultSrc;
      regWriteW_q  <= regWriteM_q;
      resultSrcW_q <= resultSrcM_q;
    end
  end

`ifdef BRANCH_COND_EN
  logic [2:0] funct3E_d;
  logic [2:0] funct3E_q;

  // funct3 follows the same flush/stall rules as the bundle.
  always_comb begin
    funct3E_d = funct3D;
    if (FlushE) begin
      funct3E_d = 3'b000;
    end else if (StallE) begin
      funct3E_d = funct3E_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      funct3E_q <= 3'b000;
    end else begin
      funct3E_q <= funct3E_d;
    end
  end

  // funct3[0] inverts the base condition; 010/011 never take.
  always_comb begin
    branchCond = 1'b0;
    case (funct3E_q)
      3'b000:  branchCond = ZeroE;
      3'b001:  branchCond = !ZeroE;
      3'b100:  branchCond = LtE;
      3'b101:  branchCond = !LtE;
      3'b110:  branchCond = LtuE;
      3'b111:  branchCond = !LtuE;
      default: branchCond = 1'b0;
    endcase
  end
`else
  logic unusedBranchFlags;

  assign unusedBranchFlags = LtE ^ LtuE;
  assign branchCond        = ZeroE;
`endif

  assign PCSrcE = ctrlE_q.jump | (ctrlE_q.branch & branchCond);

  assign RegWriteE   = ctrlE_q.regWrite;
  assign MemWriteE   = ctrlE_q.memWrite;
  assign ALUSrcE     = ctrlE_q.aluSrc;
  assign JumpE       = ctrlE_q.jump;
  assign BranchE     = ctrlE_q.branch;
  assign ALUControlE = ALUCTRL_W'(ctrlE_q.aluControl);
  assign ResultSrcE  = RESULTSRC_W'(ctrlE_q.resultSrc);
  assign RegWriteM   = regWriteM_q;
  assign MemWriteM   = memWriteM_q;
  assign ResultSrcM  = RESULTSRC_W'(resultSrcM_q);
  assign RegWriteW   = regWriteW_q;
  assign ResultSrcW  = RESULTSRC_W'(resultSrcW_q);

endmodule
